// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: redirect input, imem request/response, decode output.
// master = fetch queue side, slave = memory/decode/branch side.
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;

    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_fault
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_fault
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited in-order fetch, epoch-based flush.
// Optional misaligned-redirect fault entry: define IFETCH_MISALIGN_FAULT_EN.
module ifetch_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic            clk,
    input logic            rst,
    ifetch_queue_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_e;

    state_e        state_q, state_d;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          epoch_q, epoch_d;
    logic [CW-1:0] outst_q, outst_d;

    logic [31:0]      tag_pc_q [DEPTH];
    logic [31:0]      tag_pc_d [DEPTH];
    logic [DEPTH-1:0] tag_ep_q, tag_ep_d;
    logic [AW-1:0]    tag_wr_q, tag_wr_d;
    logic [AW-1:0]    tag_rd_q, tag_rd_d;

    logic [31:0]      q_pc_q    [DEPTH];
    logic [31:0]      q_pc_d    [DEPTH];
    logic [31:0]      q_instr_q [DEPTH];
    logic [31:0]      q_instr_d [DEPTH];
`ifdef IFETCH_MISALIGN_FAULT_EN
    logic [DEPTH-1:0] q_fault_q, q_fault_d;
`endif
    logic [AW-1:0]    q_wr_q, q_wr_d;
    logic [AW-1:0]    q_rd_q, q_rd_d;
    logic [CW-1:0]    count_q, count_d;

    logic req_ok;
    logic req_valid;
    logic req_fire;
    logic rsp_fire;
    logic rsp_live;
    logic head_valid;
    logic deq;

`ifndef IFETCH_MISALIGN_FAULT_EN
    logic unused_cfg;
    assign unused_cfg = ^{bus.redirect_pc[1:0], NOP_INSTR};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect re-enters FETCH, or HALT on a misaligned target.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = S_FETCH;
`ifdef IFETCH_MISALIGN_FAULT_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d = S_HALT;
            end
`endif
        end
    end

    // Request output: FETCH state, no redirect, free credit, out of reset.
    always_comb begin
        req_ok = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C;
        req_valid = rst && (state_q == S_FETCH)
                    && !bus.redirect_valid && req_ok;
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = fetch_pc_q;
    end

    // Handshake events; responses in the redirect cycle count as stale.
    always_comb begin
        head_valid = count_q != '0;
        req_fire   = req_valid && bus.imem_req_ready;
        rsp_fire   = bus.imem_rsp_valid && (outst_q != '0);
        rsp_live   = rsp_fire && !bus.redirect_valid
                     && (tag_ep_q[tag_rd_q] == epoch_q);
        deq        = head_valid && bus.out_ready;
    end

    // Fetch address, epoch, credits and the in-flight tag FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        outst_d    = outst_q;
        tag_pc_d   = tag_pc_q;
        tag_ep_d   = tag_ep_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        if (req_fire) begin
            tag_pc_d[tag_wr_q] = fetch_pc_q;
            tag_ep_d[tag_wr_q] = epoch_q;
            tag_wr_d   = tag_wr_q + PTR_ONE;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_fire) begin
            tag_rd_d = tag_rd_q + PTR_ONE;
        end
        unique case ({req_fire, rsp_fire})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            epoch_d    = !epoch_q;
        end
    end

    // Fetch-side registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            outst_q    <= '0;
            tag_ep_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_pc_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            outst_q    <= outst_d;
            tag_ep_q   <= tag_ep_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            tag_pc_q   <= tag_pc_d;
        end
    end

    // Instruction queue: flush on redirect, else enqueue live rsp / dequeue.
    always_comb begin
        q_pc_d    = q_pc_q;
        q_instr_d = q_instr_q;
`ifdef IFETCH_MISALIGN_FAULT_EN
        q_fault_d = q_fault_q;
`endif
        q_wr_d    = q_wr_q;
        q_rd_d    = q_rd_q;
        count_d   = count_q;
        if (bus.redirect_valid) begin
            q_wr_d  = '0;
            q_rd_d  = '0;
            count_d = '0;
`ifdef IFETCH_MISALIGN_FAULT_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                q_pc_d[0]    = bus.redirect_pc;
                q_instr_d[0] = NOP_INSTR;
                q_fault_d[0] = 1'b1;
                q_wr_d       = PTR_ONE;
                count_d      = CNT_ONE;
            end
`endif
        end else begin
            if (rsp_live) begin
                q_pc_d[q_wr_q]    = tag_pc_q[tag_rd_q];
                q_instr_d[q_wr_q] = bus.imem_rsp_data;
`ifdef IFETCH_MISALIGN_FAULT_EN
                q_fault_d[q_wr_q] = 1'b0;
`endif
                q_wr_d = q_wr_q + PTR_ONE;
            end
            if (deq) begin
                q_rd_d = q_rd_q + PTR_ONE;
            end
            unique case ({rsp_live, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_wr_q  <= '0;
            q_rd_q  <= '0;
            count_q <= '0;
`ifdef IFETCH_MISALIGN_FAULT_EN
            q_fault_q <= '0;
`endif
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            q_wr_q    <= q_wr_d;
            q_rd_q    <= q_rd_d;
            count_q   <= count_d;
`ifdef IFETCH_MISALIGN_FAULT_EN
            q_fault_q <= q_fault_d;
`endif
            q_pc_q    <= q_pc_d;
            q_instr_q <= q_instr_d;
        end
    end

    // Head of queue to decode; zeros when empty.
    always_comb begin
        bus.out_valid = head_valid;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        bus.out_fault = 1'b0;
        if (head_valid) begin
            bus.out_pc    = q_pc_q[q_rd_q];
            bus.out_instr = q_instr_q[q_rd_q];
`ifdef IFETCH_MISALIGN_FAULT_EN
            bus.out_fault = q_fault_q[q_rd_q];
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order fixed-latency memory.
// Memory returns addr ^ 32'hA5A5_0000; out handshakes are logged at negedge.
module tb_ifetch_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifetch_queue_if bus();

    ifetch_queue #(
        .DEPTH     (2),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int lat = 1;
    int rdy_mode = 0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_log[$];
    logic [31:0] opc_log[$];
    logic [31:0] oins_log[$];
    logic        oflt_log[$];
    int acc_n = 0;
    int rsp_n = 0;
    int max_outst = 0;

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.out_ready      = 1'b0;
    end

    // Memory: ready pattern and fixed-latency in-order responses.
    always @(posedge clk) begin
        #2;
        unique case (rdy_mode)
            0:       bus.imem_req_ready = 1'b1;
            1:       bus.imem_req_ready = cyc[0];
            default: bus.imem_req_ready = 1'b0;
        endcase
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (rst && mq_due.size() != 0 && mq_due[0] == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mq_addr[0] ^ 32'hA5A5_0000;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
    end

    // Observer: request and out handshakes of the current cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                req_log.push_back(bus.imem_req_addr);
                mq_addr.push_back(bus.imem_req_addr);
                mq_due.push_back(cyc + lat);
                acc_n++;
            end
            if (bus.imem_rsp_valid) rsp_n++;
            if (acc_n - rsp_n > max_outst) max_outst = acc_n - rsp_n;
            if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                opc_log.push_back(bus.out_pc);
                oins_log.push_back(bus.out_instr);
                oflt_log.push_back(bus.out_fault);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        opc_log.delete();
        oins_log.delete();
        oflt_log.delete();
    endtask

    task automatic do_reset(input bit check_vals);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick(3);
        if (check_vals) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_pc", bus.out_pc, 32'd0);
            chk("rst_out_instr", bus.out_instr, 32'd0);
            chk("rst_out_fault", 32'(bus.out_fault), 32'd0);
        end
        mq_addr.delete();
        mq_due.delete();
        clear_logs();
        acc_n = 0;
        rsp_n = 0;
        max_outst = 0;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$],
                                         input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic redirect(input logic [31:0] pc, input string tag);
        clear_logs();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        chk({tag, "_no_req"}, 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    logic [31:0] exp_pc [3];
    logic [31:0] exp_ins[3];

    initial begin
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        exp_ins = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008};
        #2;

        // Streaming from reset, 1-cycle memory.
        lat = 1;
        rdy_mode = 0;
        bus.out_ready = 1'b1;
        do_reset(1'b1);
        @(negedge clk);
        chk("t1_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_first_req_addr", bus.imem_req_addr, 32'd0);
        tick(20);
        chk("t1_nout_ge3", 32'(opc_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_req%0d", i), q_at(req_log, i), exp_pc[i]);
            chk($sformatf("t1_pc%0d", i), q_at(opc_log, i), exp_pc[i]);
            chk($sformatf("t1_ins%0d", i), q_at(oins_log, i), exp_ins[i]);
        end

        // Decode stalled: credits cap fetches at DEPTH.
        bus.out_ready = 1'b0;
        do_reset(1'b0);
        tick(10);
        @(negedge clk);
        chk("t2_nreq", 32'(req_log.size()), 32'd2);
        chk("t2_req_valid_off", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_head_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_head_pc_hold", bus.out_pc, 32'd0);
        chk("t2_head_ins_hold", bus.out_instr, 32'hA5A5_0000);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        tick(10);
        chk("t2_drain0", q_at(opc_log, 0), 32'h0);
        chk("t2_drain1", q_at(opc_log, 1), 32'h4);
        chk("t2_resume_req", q_at(req_log, 2), 32'h8);
        chk("t2_resume_out", q_at(opc_log, 2), 32'h8);

        // Redirect with two in flight; first response lands in that cycle.
        lat = 2;
        do_reset(1'b0);
        tick(2);
        chk("t3_two_outst", 32'(acc_n - rsp_n), 32'd2);
        redirect(32'h0000_0100, "t3");
        tick(20);
        chk("t3_first_req", q_at(req_log, 0), 32'h100);
        chk("t3_first_pc", q_at(opc_log, 0), 32'h100);
        chk("t3_first_ins", q_at(oins_log, 0), 32'hA5A5_0100);
        chk("t3_second_pc", q_at(opc_log, 1), 32'h104);

        // Toggling ready, 3-cycle memory: order kept, credits respected.
        lat = 3;
        rdy_mode = 1;
        do_reset(1'b0);
        tick(80);
        chk("t4_nout_ge8", 32'(opc_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_req%0d", i), q_at(req_log, i), 32'(4 * i));
            chk($sformatf("t4_pc%0d", i), q_at(opc_log, i), 32'(4 * i));
        end
        chk("t4_max_outst_le2", 32'(max_outst <= 2), 32'd1);

        // Address wrap; redirect right after reset while a request is due.
        lat = 1;
        rdy_mode = 0;
        do_reset(1'b0);
        redirect(32'hFFFF_FFF8, "t5");
        tick(15);
        chk("t5_req0", q_at(req_log, 0), 32'hFFFF_FFF8);
        chk("t5_req1", q_at(req_log, 1), 32'hFFFF_FFFC);
        chk("t5_req2_wrap", q_at(req_log, 2), 32'h0);
        chk("t5_out2_wrap", q_at(opc_log, 2), 32'h0);

        // Misaligned redirect target.
        redirect(32'h0000_0102, "t6");
`ifdef IFETCH_MISALIGN_FAULT_EN
        chk("t6_fault_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_fault_pc", bus.out_pc, 32'h102);
        chk("t6_fault_ins", bus.out_instr, 32'h13);
        chk("t6_fault_flag", 32'(bus.out_fault), 32'd1);
        tick(10);
        chk("t6_nout", 32'(opc_log.size()), 32'd1);
        chk("t6_halt_nreq", 32'(req_log.size()), 32'd0);
        redirect(32'h0000_0200, "t6b");
        tick(10);
        chk("t6b_req0", q_at(req_log, 0), 32'h200);
        chk("t6b_pc0", q_at(opc_log, 0), 32'h200);
        chk("t6b_ins0", q_at(oins_log, 0), 32'hA5A5_0200);
        chk("t6b_flt0", 32'(oflt_log.size() > 0 && oflt_log[0]), 32'd0);
`else
        tick(10);
        chk("t6_req0_aligned", q_at(req_log, 0), 32'h100);
        chk("t6_pc0_aligned", q_at(opc_log, 0), 32'h100);
        chk("t6_ins0", q_at(oins_log, 0), 32'hA5A5_0100);
        chk("t6_nofault", 32'(oflt_log.size() > 0 && oflt_log[0]), 32'd0);
        chk("t6_nout_ge1", 32'(opc_log.size() >= 1), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
